d_ff_stream_checker: RTL

Receive-side checker for serial bit streams. It samples the Q/Qn pair of a flop under test, or any registered serial bit, once per clock. It compares each sample against a programmed expected pattern, counts mismatches, and flags any cycle where Q and Qn are not complementary. It is the capture end paired with the stimulus that drives D, and it produces a self-checking pass/fail result.

---
 rtl/d_ff_stream_checker.sv | 100 ++++++++++
 1 files changed

// File: rtl/d_ff_stream_checker.sv
// d_ff_stream_checker: capture-side checker for a serial bit stream.
// Samples q/qn once per clock for LEN cycles after an accepted start.
// Each q sample is compared against a captured expected pattern, LSB first.
// Mismatches are counted with saturation, and any cycle with q==qn is flagged.
// The run ends with a pass/fail verdict and a one-cycle done pulse.
module d_ff_stream_checker #(
  parameter int LEN   = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN-1:0]   pattern,
  input  logic             q,
  input  logic             qn,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             compl_err
);

  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t           state_q;
  logic [LEN-1:0]   shadow_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] err_q, err_d;
  logic             compl_q, compl_d;
  logic             pass_q, busy_q, done_q;

  logic mis, cbad, sat, last;

  // Per-sample evaluation: the next counter and flag values if this cycle is sampled
  always_comb begin
    mis     = q ^ shadow_q[0];
    cbad    = ~(q ^ qn);
    sat     = (err_q == {CNT_W{1'b1}});
    last    = (idx_q == LAST_IDX);
    err_d   = (mis && !sat) ? err_q + CNT_W'(1) : err_q;
    compl_d = compl_q | cbad;
  end

  // Run sequencer: IDLE/DONE accept start, CHECK shifts through LEN samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      err_q    <= '0;
      compl_q  <= 1'b0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= CHECK;
            shadow_q <= pattern;
            idx_q    <= '0;
            err_q    <= '0;
            compl_q  <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        CHECK: begin
          // start is deliberately ignored here: runs cannot be aborted or queued
          shadow_q <= shadow_q >> 1;
          idx_q    <= idx_q + IDX_W'(1);
          err_q    <= err_d;
          compl_q  <= compl_d;
          if (last) begin
            state_q <= DONE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // Verdict includes the final sample, so use the next-state values
            pass_q  <= (err_d == '0) && !compl_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign compl_err = compl_q;

endmodule
